// File: rtl/eth_traffic_csr_avmm_initiator_pkg.sv
// eth_traffic_csr_init_pkg
// Local definitions for the Ethernet traffic CSR AVMM initiator.
//   state_t     : initiator FSM states (also exported on the debug port).
//   tmo_cnt_w() : width of the per-dword read timeout counter.
package eth_traffic_csr_init_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_LO   = 3'd1,
        ST_WR_HI   = 3'd2,
        ST_RD_LO   = 3'd3,
        ST_RD_LO_W = 3'd4,
        ST_RD_HI   = 3'd5,
        ST_RD_HI_W = 3'd6,
        ST_RSP     = 3'd7
    } state_t;

    // Counter must be able to hold TIMEOUT_CYCLES itself.
    function automatic int tmo_cnt_w(input int cycles);
        return $clog2(cycles + 1);
    endfunction

    localparam int TMO_CNT_W_DEFAULT = tmo_cnt_w(256);

endpackage : eth_traffic_csr_init_pkg

// File: rtl/ofs_csr_pkg.sv
// ofs_csr_pkg
// Shared CSR access definitions used by the OFS CSR blocks.
//   csr_access_type_t : selects which 32-bit halves of a 64-bit CSR a write
//                       touches (FULL64, UPPER32, LOWER32).
package ofs_csr_pkg;

    typedef enum logic [1:0] {
        FULL64  = 2'd0,
        UPPER32 = 2'd1,
        LOWER32 = 2'd2
    } csr_access_type_t;

endpackage : ofs_csr_pkg

// File: rtl/eth_traffic_csr_avmm_initiator_if.sv
// Bus bundles for the Ethernet traffic CSR AVMM initiator.
//
// eth_traffic_csr_req_if : 64-bit CSR command/response channel.
//   master = command source, slave = initiator.
//   Handshake: a request transfers on a clock edge where i_req_valid and
//   o_req_ready are both high; the source holds all i_req_* stable while
//   valid is high and ready is low. o_rsp_valid is a single-cycle pulse
//   with no back-pressure; o_rsp_rdata/o_rsp_timeout qualify with it.
//
// eth_traffic_csr_avmm_if : 32-bit Avalon-MM channel.
//   master = initiator, slave = CSR responder.
//   A command (read or write) transfers on an edge where it is asserted and
//   i_avmm_waitrequest is low; read data returns later with
//   i_avmm_readdatavalid.
interface eth_traffic_csr_req_if #(
    parameter int AVMM_ADDR_W = 16
);
    logic                            i_req_valid;
    logic                            o_req_ready;
    logic                            i_req_write;
    logic [AVMM_ADDR_W-1:0]          i_req_addr;
    ofs_csr_pkg::csr_access_type_t   i_req_wr_type;
    logic [63:0]                     i_req_wdata;
    logic                            o_rsp_valid;
    logic [63:0]                     o_rsp_rdata;
    logic                            o_rsp_timeout;

    modport master (
        output i_req_valid, i_req_write, i_req_addr, i_req_wr_type, i_req_wdata,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_timeout
    );

    modport slave (
        input  i_req_valid, i_req_write, i_req_addr, i_req_wr_type, i_req_wdata,
        output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_timeout
    );
endinterface : eth_traffic_csr_req_if

interface eth_traffic_csr_avmm_if #(
    parameter int AVMM_ADDR_W = 16
);
    logic [AVMM_ADDR_W-1:0] o_avmm_address;
    logic                   o_avmm_read;
    logic                   o_avmm_write;
    logic [31:0]            o_avmm_writedata;
    logic [3:0]             o_avmm_byteenable;
    logic                   i_avmm_waitrequest;
    logic [31:0]            i_avmm_readdata;
    logic                   i_avmm_readdatavalid;

    modport master (
        output o_avmm_address, o_avmm_read, o_avmm_write, o_avmm_writedata,
               o_avmm_byteenable,
        input  i_avmm_waitrequest, i_avmm_readdata, i_avmm_readdatavalid
    );

    modport slave (
        input  o_avmm_address, o_avmm_read, o_avmm_write, o_avmm_writedata,
               o_avmm_byteenable,
        output i_avmm_waitrequest, i_avmm_readdata, i_avmm_readdatavalid
    );
endinterface : eth_traffic_csr_avmm_if

// File: rtl/eth_traffic_csr_avmm_initiator.sv
// eth_traffic_csr_avmm_initiator
// Splits single 64-bit CSR requests into one or two 32-bit Avalon-MM
// transactions, reassembles read data and answers each request with one
// response pulse. A read dword that does not return within TIMEOUT_CYCLES
// is replaced by TIMEOUT_DATA and flagged.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   req          : 64-bit request/response channel (slave side)
//   avmm         : 32-bit AVMM channel (master side)
//   o_dbg_state  : current FSM state
module eth_traffic_csr_avmm_initiator
    import ofs_csr_pkg::*;
    import eth_traffic_csr_init_pkg::*;
#(
    parameter int          AVMM_ADDR_W    = 16,
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
    input  logic                    clk,
    input  logic                    rst,
    eth_traffic_csr_req_if.slave    req,
    eth_traffic_csr_avmm_if.master  avmm,
    output state_t                  o_dbg_state
);

    localparam int                     CNT_W    = tmo_cnt_w(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]       CNT_ONE  = CNT_W'(1);
    localparam logic [AVMM_ADDR_W-1:0] HI_OFS   = AVMM_ADDR_W'(4);

    state_t                 state;
    logic [AVMM_ADDR_W-1:0] addr_q;
    logic [63:0]            wdata_q;
    csr_access_type_t       wr_type_q;
    logic [CNT_W-1:0]       cnt;
    logic                   tmo_flag;
    logic [31:0]            rd_lo_q;
    logic [31:0]            rd_hi_q;

    logic                   ready_q;
    logic                   rsp_valid_q;
    logic [63:0]            rsp_rdata_q;
    logic                   rsp_timeout_q;
    logic [AVMM_ADDR_W-1:0] av_addr_q;
    logic                   av_read_q;
    logic                   av_write_q;
    logic [31:0]            av_wdata_q;
    logic [3:0]             av_be_q;

    // 64-bit CSRs are 8-byte aligned; the low address bits are dropped.
    logic [AVMM_ADDR_W-1:0] req_addr_al;
    assign req_addr_al = {req.i_req_addr[AVMM_ADDR_W-1:3], 3'b000};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            wr_type_q     <= FULL64;
            cnt           <= '0;
            tmo_flag      <= 1'b0;
            rd_lo_q       <= '0;
            rd_hi_q       <= '0;
            ready_q       <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b0;
            av_addr_q     <= '0;
            av_read_q     <= 1'b0;
            av_write_q    <= 1'b0;
            av_wdata_q    <= '0;
            av_be_q       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req.i_req_valid && ready_q) begin
                        ready_q   <= 1'b0;
                        tmo_flag  <= 1'b0;
                        addr_q    <= req_addr_al;
                        wdata_q   <= req.i_req_wdata;
                        wr_type_q <= req.i_req_wr_type;
                        av_be_q   <= 4'hF;
                        if (!req.i_req_write) begin
                            state     <= ST_RD_LO;
                            av_read_q <= 1'b1;
                            av_addr_q <= req_addr_al;
                            av_wdata_q <= '0;
                        end else if (req.i_req_wr_type == UPPER32) begin
                            state      <= ST_WR_HI;
                            av_write_q <= 1'b1;
                            av_addr_q  <= req_addr_al + HI_OFS;
                            av_wdata_q <= req.i_req_wdata[63:32];
                        end else begin
                            state      <= ST_WR_LO;
                            av_write_q <= 1'b1;
                            av_addr_q  <= req_addr_al;
                            av_wdata_q <= req.i_req_wdata[31:0];
                        end
                    end
                end
                ST_WR_LO: begin
                    if (!avmm.i_avmm_waitrequest) begin
                        if (wr_type_q == FULL64) begin
                            state      <= ST_WR_HI;
                            av_addr_q  <= addr_q + HI_OFS;
                            av_wdata_q <= wdata_q[63:32];
                        end else begin
                            state         <= ST_RSP;
                            av_write_q    <= 1'b0;
                            av_be_q       <= '0;
                            rsp_valid_q   <= 1'b1;
                            rsp_rdata_q   <= '0;
                            rsp_timeout_q <= 1'b0;
                        end
                    end
                end
                ST_WR_HI: begin
                    if (!avmm.i_avmm_waitrequest) begin
                        state         <= ST_RSP;
                        av_write_q    <= 1'b0;
                        av_be_q       <= '0;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= '0;
                        rsp_timeout_q <= 1'b0;
                    end
                end
                ST_RD_LO: begin
                    if (!avmm.i_avmm_waitrequest) begin
                        state     <= ST_RD_LO_W;
                        av_read_q <= 1'b0;
                        av_be_q   <= '0;
                        cnt       <= '0;
                    end
                end
                ST_RD_LO_W: begin
                    if (avmm.i_avmm_readdatavalid || cnt == CNT_LAST) begin
                        rd_lo_q   <= avmm.i_avmm_readdatavalid ? avmm.i_avmm_readdata
                                                               : TIMEOUT_DATA;
                        tmo_flag  <= tmo_flag | !avmm.i_avmm_readdatavalid;
                        state     <= ST_RD_HI;
                        av_read_q <= 1'b1;
                        av_be_q   <= 4'hF;
                        av_addr_q <= addr_q + HI_OFS;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_RD_HI: begin
                    if (!avmm.i_avmm_waitrequest) begin
                        state     <= ST_RD_HI_W;
                        av_read_q <= 1'b0;
                        av_be_q   <= '0;
                        cnt       <= '0;
                    end
                end
                ST_RD_HI_W: begin
                    // Reads enter RSP with the pulse still low; the 64-bit
                    // response word is assembled there one cycle later.
                    if (avmm.i_avmm_readdatavalid || cnt == CNT_LAST) begin
                        rd_hi_q  <= avmm.i_avmm_readdatavalid ? avmm.i_avmm_readdata
                                                              : TIMEOUT_DATA;
                        tmo_flag <= tmo_flag | !avmm.i_avmm_readdatavalid;
                        state    <= ST_RSP;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_RSP: begin
                    if (rsp_valid_q) begin
                        rsp_valid_q <= 1'b0;
                        ready_q     <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= {rd_hi_q, rd_lo_q};
                        rsp_timeout_q <= tmo_flag;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign req.o_req_ready        = ready_q;
    assign req.o_rsp_valid        = rsp_valid_q;
    assign req.o_rsp_rdata        = rsp_rdata_q;
    assign req.o_rsp_timeout      = rsp_timeout_q;
    assign avmm.o_avmm_address    = av_addr_q;
    assign avmm.o_avmm_read       = av_read_q;
    assign avmm.o_avmm_write      = av_write_q;
    assign avmm.o_avmm_writedata  = av_wdata_q;
    assign avmm.o_avmm_byteenable = av_be_q;
    assign o_dbg_state            = state;

endmodule : eth_traffic_csr_avmm_initiator

// File: tb/tb_eth_traffic_csr_avmm_initiator.sv
// Directed bench for eth_traffic_csr_avmm_initiator. Cycle 0 is the cycle in
// which a request is presented with o_req_ready high. All DUT outputs are
// sampled and all inputs driven at the falling edge.
module tb_eth_traffic_csr_avmm_initiator;
    import ofs_csr_pkg::*;
    import eth_traffic_csr_init_pkg::*;

    localparam int AW  = 16;
    localparam int TMO = 16;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    state_t dbg_state;

    eth_traffic_csr_req_if  #(.AVMM_ADDR_W(AW)) req_if ();
    eth_traffic_csr_avmm_if #(.AVMM_ADDR_W(AW)) bus_if ();

    eth_traffic_csr_avmm_initiator #(
        .AVMM_ADDR_W    (AW),
        .TIMEOUT_CYCLES (TMO),
        .TIMEOUT_DATA   (32'hDEAD_BEEF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req_if),
        .avmm        (bus_if),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- scoreboard: {write, address, writedata} ----------------
    logic [48:0] exp_q[$];

    task automatic exp_cmd(input logic wr, input logic [15:0] addr, input logic [31:0] data);
        exp_q.push_back({wr, addr, data});
    endtask

    // ---------------- responder model state ----------------
    logic [31:0] rd_data_q[$];
    int          rd_lat      = 1;
    int          rd_answers  = 0;
    bit          pending     = 0;
    int          due         = 0;
    int          wait_budget = 0;
    bit          stray_req   = 0;
    bit          prev_wait   = 0;
    logic [15:0] prev_addr;
    logic [31:0] prev_data;
    logic [1:0]  prev_cmd;

    int          rsp_cnt  = 0;
    bit          rsp_seen = 0;
    int          rsp_cyc  = 0;
    logic [63:0] rsp_rdata_s;
    logic        rsp_tmo_s;
    int          t0 = 0;

    // One clock cycle: observe the DUT for this cycle and drive the
    // responder inputs that it will sample at the next rising edge.
    task automatic tick();
        logic [48:0] obs;
        logic        cmd;
        @(negedge clk);
        if (prev_wait) begin
            check("hold_addr", bus_if.o_avmm_address, prev_addr);
            check("hold_data", bus_if.o_avmm_writedata, prev_data);
            check("hold_cmd", {bus_if.o_avmm_read, bus_if.o_avmm_write}, prev_cmd);
        end
        bus_if.i_avmm_readdatavalid = 1'b0;
        bus_if.i_avmm_readdata      = '0;
        if (pending && cyc == due) begin
            bus_if.i_avmm_readdatavalid = 1'b1;
            bus_if.i_avmm_readdata      = rd_data_q.pop_front();
            pending = 0;
        end else if (stray_req) begin
            bus_if.i_avmm_readdatavalid = 1'b1;
            bus_if.i_avmm_readdata      = 32'h5A5A_5A5A;
            stray_req = 0;
        end
        cmd = bus_if.o_avmm_read | bus_if.o_avmm_write;
        if (cmd && wait_budget > 0) begin
            bus_if.i_avmm_waitrequest = 1'b1;
            wait_budget--;
        end else begin
            bus_if.i_avmm_waitrequest = 1'b0;
        end
        prev_wait = cmd && bus_if.i_avmm_waitrequest;
        prev_addr = bus_if.o_avmm_address;
        prev_data = bus_if.o_avmm_writedata;
        prev_cmd  = {bus_if.o_avmm_read, bus_if.o_avmm_write};
        if (cmd && !bus_if.i_avmm_waitrequest) begin
            check("cmd_byteenable", bus_if.o_avmm_byteenable, 4'hF);
            obs = {bus_if.o_avmm_write, bus_if.o_avmm_address,
                   bus_if.o_avmm_write ? bus_if.o_avmm_writedata : 32'h0};
            check("cmd_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("cmd", obs, exp_q.pop_front());
            if (bus_if.o_avmm_read && rd_answers > 0) begin
                pending = 1;
                due     = cyc + rd_lat;
                rd_answers--;
            end
        end
        if (req_if.o_rsp_valid) begin
            rsp_cnt++;
            rsp_seen    = 1;
            rsp_cyc     = cyc;
            rsp_rdata_s = req_if.o_rsp_rdata;
            rsp_tmo_s   = req_if.o_rsp_timeout;
            check("rsp_ready_low", req_if.o_req_ready, 0);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_req(input logic wr, input logic [15:0] addr,
                          input csr_access_type_t t, input logic [63:0] wd);
        tick();
        check("req_ready", req_if.o_req_ready, 1);
        req_if.i_req_valid   = 1'b1;
        req_if.i_req_write   = wr;
        req_if.i_req_addr    = addr;
        req_if.i_req_wr_type = t;
        req_if.i_req_wdata   = wd;
        t0       = cyc;
        rsp_seen = 0;
        tick();
        req_if.i_req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int exp_lat,
                            input logic [63:0] exp_rdata, input logic exp_tmo);
        int n = 0;
        while (!rsp_seen && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_seen"}, rsp_seen, 1);
        if (rsp_seen) begin
            check({tag, "_latency"}, rsp_cyc - t0, exp_lat);
            check({tag, "_rdata"}, rsp_rdata_s, exp_rdata);
            check({tag, "_timeout"}, rsp_tmo_s, exp_tmo);
        end
        check({tag, "_cmds_done"}, exp_q.size(), 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, req_if.o_req_ready, 1);
        check({tag, "_rsp_valid"}, req_if.o_rsp_valid, 0);
        check({tag, "_rsp_rdata"}, req_if.o_rsp_rdata, 0);
        check({tag, "_rsp_timeout"}, req_if.o_rsp_timeout, 0);
        check({tag, "_cmd"}, {bus_if.o_avmm_read, bus_if.o_avmm_write}, 0);
        check({tag, "_address"}, bus_if.o_avmm_address, 0);
        check({tag, "_writedata"}, bus_if.o_avmm_writedata, 0);
        check({tag, "_byteenable"}, bus_if.o_avmm_byteenable, 0);
        check({tag, "_state"}, dbg_state, ST_IDLE);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int rsp_before;
        req_if.i_req_valid          = 1'b0;
        req_if.i_req_write          = 1'b0;
        req_if.i_req_addr           = '0;
        req_if.i_req_wr_type        = FULL64;
        req_if.i_req_wdata          = '0;
        bus_if.i_avmm_waitrequest   = 1'b0;
        bus_if.i_avmm_readdata      = '0;
        bus_if.i_avmm_readdatavalid = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        // FULL64 write, no waitrequest
        exp_cmd(1'b1, 16'h0048, 32'h5566_7788);
        exp_cmd(1'b1, 16'h004C, 32'h1122_3344);
        do_req(1'b1, 16'h0048, FULL64, 64'h1122_3344_5566_7788);
        wait_rsp("wr_full64", 3, 64'h0, 1'b0);

        // UPPER32 write, unaligned address
        exp_cmd(1'b1, 16'h0014, 32'hAABB_CCDD);
        do_req(1'b1, 16'h0013, UPPER32, 64'hAABB_CCDD_0102_0304);
        wait_rsp("wr_upper32", 2, 64'h0, 1'b0);

        // LOWER32 write
        exp_cmd(1'b1, 16'h0100, 32'h0102_0304);
        do_req(1'b1, 16'h0105, LOWER32, 64'hAABB_CCDD_0102_0304);
        wait_rsp("wr_lower32", 2, 64'h0, 1'b0);

        // Read, latency 4
        rd_lat = 4; rd_answers = 2;
        rd_data_q.push_back(32'hCAFE_0001);
        rd_data_q.push_back(32'hCAFE_0002);
        exp_cmd(1'b0, 16'h0020, 32'h0);
        exp_cmd(1'b0, 16'h0024, 32'h0);
        do_req(1'b0, 16'h0020, FULL64, 64'h0);
        wait_rsp("rd_lat4", 12, 64'hCAFE_0002_CAFE_0001, 1'b0);

        // FULL64 write with 5 waitrequest cycles on WR_LO
        wait_budget = 5;
        exp_cmd(1'b1, 16'h0080, 32'h1234_5678);
        exp_cmd(1'b1, 16'h0084, 32'h0BAD_F00D);
        do_req(1'b1, 16'h0080, FULL64, 64'h0BAD_F00D_1234_5678);
        wait_rsp("wr_waitreq", 8, 64'h0, 1'b0);

        // Read whose upper dword never returns
        rd_lat = 2; rd_answers = 1;
        rd_data_q.push_back(32'hA5A5_0001);
        exp_cmd(1'b0, 16'h0030, 32'h0);
        exp_cmd(1'b0, 16'h0034, 32'h0);
        do_req(1'b0, 16'h0030, FULL64, 64'h0);
        wait_rsp("rd_timeout", 22, 64'hDEAD_BEEF_A5A5_0001, 1'b1);

        // Stray readdatavalid while idle is ignored
        rsp_before = rsp_cnt;
        stray_req = 1;
        tick();
        tick();
        check("stray_state", dbg_state, ST_IDLE);
        check("stray_no_rsp", rsp_cnt, rsp_before);

        // Next read completes cleanly with timeout cleared
        rd_lat = 1; rd_answers = 2;
        rd_data_q.push_back(32'h0000_0011);
        rd_data_q.push_back(32'h0000_0022);
        exp_cmd(1'b0, 16'h0040, 32'h0);
        exp_cmd(1'b0, 16'h0044, 32'h0);
        do_req(1'b0, 16'h0040, FULL64, 64'h0);
        wait_rsp("rd_after_tmo", 6, 64'h0000_0022_0000_0011, 1'b0);

        // Reset during RD_HI_W
        rd_lat = 3; rd_answers = 1;
        rd_data_q.push_back(32'h0000_0077);
        exp_cmd(1'b0, 16'h0050, 32'h0);
        exp_cmd(1'b0, 16'h0054, 32'h0);
        rsp_before = rsp_cnt;
        do_req(1'b0, 16'h0050, FULL64, 64'h0);
        n = 0;
        while (dbg_state != ST_RD_HI_W && n < 40) begin
            tick();
            n++;
        end
        check("reach_rd_hi_w", dbg_state, ST_RD_HI_W);
        tick();
        rst = 1'b1;
        #1;
        check_reset_values("midrst");
        pending = 0; wait_budget = 0; prev_wait = 0;
        rd_answers = 0;
        rd_data_q.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("midrst_no_rsp", rsp_cnt, rsp_before);
        check("midrst_cmds_done", exp_q.size(), 0);

        // Normal request after the mid-operation reset
        exp_cmd(1'b1, 16'h0060, 32'h8765_4321);
        do_req(1'b1, 16'h0060, LOWER32, 64'hFFFF_FFFF_8765_4321);
        wait_rsp("wr_after_rst", 2, 64'h0, 1'b0);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_eth_traffic_csr_avmm_initiator
